// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// handles ready/timeout memory handshakes and counts retired instructions. Option: MCTRL_JAL_EN.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [5:0]       instr_op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic [1:0]       RegDst_o,
  output logic [1:0]       MemToReg_o,
  output logic             RegWrite_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic [1:0]       PCSource_o,
  output logic             illegal_o,
  output logic             err_o,
  output logic             instr_done_o,
  output logic [CNT_W-1:0] instr_count_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCTRL_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  localparam bit TMO_EN = (MEM_TIMEOUT > 0);
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_ADDR= 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_EXEC_R  = 4'd7,
    S_R_WB    = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_TRAP    = 4'd13
`ifdef MCTRL_JAL_EN
    , S_JAL   = 4'd14
`endif
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic                tmo_hit_s;
  logic [CNT_W-1:0]    count_r;

  // The current wait state has used up its budget of low-ready cycles
  assign tmo_hit_s     = TMO_EN && !mem_ready_i && (wait_cnt_r == WAIT_LIM);
  assign instr_count_o = count_r;

  // State register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Wait counter: restarts on every state entry (including a timeout re-entry of FETCH)
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if ((next_state_s != state_r) || err_o) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (!mem_ready_i && (wait_cnt_r != {WAIT_W{1'b1}})) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (instr_done_o) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    next_state_s = state_r;
    PCWrite_o    = 1'b0;
    IorD_o       = 1'b0;
    MemRead_o    = 1'b0;
    MemWrite_o   = 1'b0;
    IRWrite_o    = 1'b0;
    RegDst_o     = 2'b00;
    MemToReg_o   = 2'b00;
    RegWrite_o   = 1'b0;
    ALUSrcA_o    = 1'b0;
    ALUSrcB_o    = 2'b00;
    ALUOp_o      = 2'b00;
    PCSource_o   = 2'b00;
    illegal_o    = 1'b0;
    err_o        = 1'b0;
    instr_done_o = 1'b0;
    case (state_r)
      S_IDLE: next_state_s = S_FETCH;
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        if (mem_ready_i) begin
          IRWrite_o    = 1'b1;
          PCWrite_o    = 1'b1;
          next_state_s = S_DECODE;
        end else if (tmo_hit_s) begin
          err_o        = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB_o = 2'b11;
        case (instr_op_i)
          OP_RTYPE:          next_state_s = S_EXEC_R;
          OP_ADDI, OP_ADDIU: next_state_s = S_ADDI_EX;
          OP_LW, OP_SW:      next_state_s = S_MEM_ADDR;
          OP_BEQ, OP_BNE:    next_state_s = S_BRANCH;
          OP_J:              next_state_s = S_JUMP;
`ifdef MCTRL_JAL_EN
          OP_JAL:            next_state_s = S_JAL;
`endif
          default:           next_state_s = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        if (instr_op_i == OP_LW) begin
          next_state_s = S_MEM_RD;
        end else begin
          next_state_s = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i) begin
          next_state_s = S_MEM_WB;
        end else if (tmo_hit_s) begin
          err_o        = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEM_RD;
        end
      end
      S_MEM_WB: begin
        MemToReg_o   = 2'b01;
        RegWrite_o   = 1'b1;
        instr_done_o = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
        if (mem_ready_i) begin
          instr_done_o = 1'b1;
          next_state_s = S_FETCH;
        end else if (tmo_hit_s) begin
          err_o        = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEM_WR;
        end
      end
      S_EXEC_R: begin
        ALUSrcA_o    = 1'b1;
        ALUOp_o      = 2'b10;
        next_state_s = S_R_WB;
      end
      S_R_WB: begin
        RegDst_o     = 2'b01;
        RegWrite_o   = 1'b1;
        instr_done_o = 1'b1;
        next_state_s = S_FETCH;
      end
      S_ADDI_EX: begin
        ALUSrcA_o    = 1'b1;
        ALUSrcB_o    = 2'b10;
        next_state_s = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite_o   = 1'b1;
        instr_done_o = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o    = 1'b1;
        ALUOp_o      = 2'b01;
        PCSource_o   = 2'b01;
        PCWrite_o    = (instr_op_i == OP_BNE) ? ~zero_i : zero_i;
        instr_done_o = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JUMP: begin
        PCSource_o   = 2'b10;
        PCWrite_o    = 1'b1;
        instr_done_o = 1'b1;
        next_state_s = S_FETCH;
      end
`ifdef MCTRL_JAL_EN
      S_JAL: begin
        PCSource_o   = 2'b10;
        PCWrite_o    = 1'b1;
        RegDst_o     = 2'b10;
        MemToReg_o   = 2'b10;
        RegWrite_o   = 1'b1;
        instr_done_o = 1'b1;
        next_state_s = S_FETCH;
      end
`endif
      S_TRAP: begin
        // PC was already advanced in FETCH, so the bad instruction is simply skipped
        illegal_o    = 1'b1;
        next_state_s = S_FETCH;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: an instruction-level model expands
// each instruction into its expected per-cycle control vectors, compared every cycle.
module tb_multicycle_ctrl;

  localparam int TMO = 15;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    instr_op;
  logic          zero;
  logic          mem_ready;
  logic          PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]    RegDst, MemToReg, ALUSrcB, ALUOp, PCSource;
  logic          illegal, err, instr_done;
  logic [CW-1:0] instr_count;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_n(rst_n), .instr_op_i(instr_op), .zero_i(zero), .mem_ready_i(mem_ready),
    .PCWrite_o(PCWrite), .IorD_o(IorD), .MemRead_o(MemRead), .MemWrite_o(MemWrite),
    .IRWrite_o(IRWrite), .RegDst_o(RegDst), .MemToReg_o(MemToReg), .RegWrite_o(RegWrite),
    .ALUSrcA_o(ALUSrcA), .ALUSrcB_o(ALUSrcB), .ALUOp_o(ALUOp), .PCSource_o(PCSource),
    .illegal_o(illegal), .err_o(err), .instr_done_o(instr_done), .instr_count_o(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, iord, mr, mw, irw;
    logic [1:0] regdst, m2r;
    logic rw, srca;
    logic [1:0] srcb, aluop, pcs;
    logic ill, err, done;
  } ctl_t;

  typedef struct packed {
    ctl_t          c;
    logic [CW-1:0] cnt;
  } exp_t;

  ctl_t          act;
  exp_t          q[$];
  exp_t          e_cmp;
  logic [CW-1:0] exp_cnt = '0;
  int            checks = 0, failures = 0;
  int            cyc_n = 0, last_done = 0, prev_done = 0, err_seen = 0;

  assign act = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal, err, instr_done};

  // Single compare process: checks every expected cycle, and records done/err events
  always @(negedge clk) begin
    cyc_n++;
    if (instr_done) begin
      prev_done = last_done;
      last_done = cyc_n;
    end
    if (err) err_seen++;
    if (q.size() > 0) begin
      e_cmp = q.pop_front();
      checks++;
      if (act !== e_cmp.c) begin
        failures++;
        $display("FAIL ctl cyc=%0d got=%05h exp=%05h", cyc_n, act, e_cmp.c);
      end
      checks++;
      if (instr_count !== e_cmp.cnt) begin
        failures++;
        $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc_n, instr_count, e_cmp.cnt);
      end
    end
  end

  task automatic chk(input string nm, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, expv);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Drive one cycle of inputs and queue what the outputs must be in that cycle
  task automatic step(input logic [5:0] op, input logic z, input logic rdy, input ctl_t c);
    instr_op  = op;
    zero      = z;
    mem_ready = rdy;
    q.push_back({c, exp_cnt});
    if (c.done) exp_cnt = exp_cnt + 1;
    @(posedge clk);
    #1;
  endtask

  // Expected vector for a memory-wait cycle: kind 0 fetch, 1 load, 2 store
  function automatic ctl_t ph(input int kind, input logic rdy, input logic e);
    ctl_t c = '0;
    c.err = e;
    if (kind == 0) begin
      c.mr = 1'b1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy;
    end else if (kind == 1) begin
      c.mr = 1'b1; c.iord = 1'b1;
    end else begin
      c.mw = 1'b1; c.iord = 1'b1; c.done = rdy;
    end
    return c;
  endfunction

  // A memory access with 'waits' low-ready cycles; beyond TMO of them it times out
  task automatic wait_phase(input int waits, input int kind, input logic [5:0] op,
                            input logic z, output bit ok);
    ok = 1'b1;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        step(op, z, 1'b1, ph(kind, 1'b1, 1'b0));
      end else if (i == TMO) begin
        step(op, z, 1'b0, ph(kind, 1'b0, 1'b1));
        ok = 1'b0;
        return;
      end else begin
        step(op, z, 1'b0, ph(kind, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    bit   ok;
    ctl_t c;
    wait_phase(fw, 0, op, z, ok);
    if (!ok) return;
    c = '0; c.srcb = 2'b11;
    step(op, z, rb(), c);
    case (op)
      6'b000000: begin
        c = '0; c.srca = 1'b1; c.aluop = 2'b10;            step(op, z, rb(), c);
        c = '0; c.regdst = 2'b01; c.rw = 1'b1; c.done = 1'b1; step(op, z, rb(), c);
      end
      6'b001000, 6'b001001: begin
        c = '0; c.srca = 1'b1; c.srcb = 2'b10;             step(op, z, rb(), c);
        c = '0; c.rw = 1'b1; c.done = 1'b1;                step(op, z, rb(), c);
      end
      6'b100011, 6'b101011: begin
        c = '0; c.srca = 1'b1; c.srcb = 2'b10;             step(op, z, rb(), c);
        wait_phase(mw, (op == 6'b100011) ? 1 : 2, op, z, ok);
        if (ok && op == 6'b100011) begin
          c = '0; c.m2r = 2'b01; c.rw = 1'b1; c.done = 1'b1; step(op, z, rb(), c);
        end
      end
      6'b000100, 6'b000101: begin
        c = '0; c.srca = 1'b1; c.aluop = 2'b01; c.pcs = 2'b01; c.done = 1'b1;
        c.pcw = (op == 6'b000100) ? z : ~z;
        step(op, z, rb(), c);
      end
      6'b000010: begin
        c = '0; c.pcs = 2'b10; c.pcw = 1'b1; c.done = 1'b1; step(op, z, rb(), c);
      end
`ifdef MCTRL_JAL_EN
      6'b000011: begin
        c = '0; c.pcs = 2'b10; c.pcw = 1'b1; c.regdst = 2'b10; c.m2r = 2'b10;
        c.rw = 1'b1; c.done = 1'b1;
        step(op, z, rb(), c);
      end
`endif
      default: begin
        c = '0; c.ill = 1'b1; step(op, z, rb(), c);
      end
    endcase
  endtask

  function automatic int rwait();
    int r = int'($urandom_range(0, 19));
    if (r < 12) return 0;
    if (r < 17) return int'($urandom_range(1, 3));
    if (r == 17) return TMO;
    return TMO + 1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0]    ops [0:9];
    logic [5:0]    op;
    logic [CW-1:0] c0;
    int            e0;
    ctl_t          c;
    ops = '{6'b000000, 6'b001000, 6'b001001, 6'b100011, 6'b101011,
            6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b111111};

    rst_n = 1'b0; instr_op = '0; zero = 1'b0; mem_ready = 1'b0;
    #3;
    chk("reset_outputs", act, 0);
    chk("reset_count", instr_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(6'b000000, 1'b0, rb(), '0);

    // Directed program with zero-wait memory and hand-computed latencies
    run_instr(6'b000010, 1'b0, 0, 0);
    run_instr(6'b000000, 1'b0, 0, 0); chk("lat_add", last_done - prev_done, 4);
    run_instr(6'b001000, 1'b0, 0, 0); chk("lat_addi", last_done - prev_done, 4);
    run_instr(6'b100011, 1'b0, 0, 0); chk("lat_lw", last_done - prev_done, 5);
    run_instr(6'b101011, 1'b0, 0, 0); chk("lat_sw", last_done - prev_done, 4);
    run_instr(6'b000100, 1'b1, 0, 0); chk("lat_beq", last_done - prev_done, 3);
    chk("count_after_prog", instr_count, 6);
    run_instr(6'b000101, 1'b1, 0, 0);
    run_instr(6'b100011, 1'b0, 0, 3); chk("lat_lw_wait3", last_done - prev_done, 8);

    // Store that never sees ready: one err pulse, count frozen
    e0 = err_seen; c0 = instr_count;
    run_instr(6'b101011, 1'b0, 0, 40);
    chk("tmo_err_pulses", err_seen - e0, 1);
    chk("tmo_count_same", instr_count, c0);
    run_instr(6'b111111, 1'b0, 0, 0);
    run_instr(6'b000011, 1'b0, 0, 0);
    run_instr(6'b001001, 1'b0, 0, 0);
    run_instr(6'b000010, 1'b0, TMO, 0);
    run_instr(6'b000010, 1'b0, TMO + 1, 0);

    for (int n = 0; n < 400; n++) begin
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      run_instr(op, rb(), rwait(), rwait());
    end

    // Reset in the middle of a stalled store
    run_instr(6'b000010, 1'b0, 0, 0);
    step(6'b101011, 1'b0, 1'b1, ph(0, 1'b1, 1'b0));
    c = '0; c.srcb = 2'b11;                step(6'b101011, 1'b0, rb(), c);
    c = '0; c.srca = 1'b1; c.srcb = 2'b10; step(6'b101011, 1'b0, rb(), c);
    step(6'b101011, 1'b0, 1'b0, ph(2, 1'b0, 1'b0));
    step(6'b101011, 1'b0, 1'b0, ph(2, 1'b0, 1'b0));
    chk("memwrite_before_rst", MemWrite, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_memwrite_drop", MemWrite, 0);
    chk("rst_outputs_zero", act, 0);
    chk("rst_count_zero", instr_count, 0);
    exp_cnt = '0;
    step(6'b101011, 1'b0, 1'b1, '0);
    step(6'b101011, 1'b0, 1'b1, '0);
    rst_n = 1'b1;
    step(6'b000000, 1'b0, rb(), '0);
    run_instr(6'b000000, 1'b0, 0, 0);
    chk("count_after_rst", instr_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
